// File: rtl/route_edge_scheduler.sv
// Edge-routing request sequencer for the 4x4 CGRA routing engine.
// Buffers {src,dst} edges in a FIFO, issues them one at a time over a
// req/ack handshake, re-queues failed edges until their retry budget is
// spent, and reports routed/failed totals plus a sticky done flag.
module route_edge_scheduler #(
    parameter int DEPTH     = 16,
    parameter int MAX_RETRY = 2,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_edge,
    input  logic             in_last,
    output logic             rt_req,
    output logic [7:0]       rt_edge,
    input  logic             rt_ack,
    input  logic             rt_done,
    input  logic             rt_ok,
    output logic [CNT_W-1:0] routed_cnt,
    output logic [CNT_W-1:0] failed_cnt,
    output logic             busy,
    output logic             done
);
    localparam int PW = $clog2(DEPTH);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [PW:0]   FULL = (PW+1)'(DEPTH);
    localparam logic [RW-1:0] RMAX = RW'(MAX_RETRY);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] POP     = 3'd1;
    localparam logic [2:0] ISSUE   = 3'd2;
    localparam logic [2:0] WAIT    = 3'd3;
    localparam logic [2:0] RESOLVE = 3'd4;
    localparam logic [2:0] FINISH  = 3'd5;

    typedef struct packed {
        logic [RW-1:0] retry;
        logic [7:0]    rte;
    } entry_t;

    entry_t        mem [DEPTH];
    entry_t        head, cur, wr_data;
    logic [2:0]    state;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [PW:0]   count;
    logic          last_seen, res_ok;
    logic          in_flight, requeue, push_in, do_wr, do_pop, self_route;
    logic          inc_routed, inc_failed;

    assign head       = mem[rd_ptr];
    assign in_flight  = (state == POP) || (state == ISSUE) || (state == WAIT) || (state == RESOLVE);
    assign requeue    = (state == RESOLVE) && !res_ok && (cur.retry < RMAX);
    // One slot stays reserved while an edge is out so its re-queue always fits.
    assign in_ready   = !last_seen && !requeue &&
                        (in_flight ? (count < FULL - 1'b1) : (count < FULL));
    assign push_in    = in_valid && in_ready;
    assign do_wr      = push_in || requeue;
    assign do_pop     = (state == POP);
    assign self_route = (head.rte[7:4] == head.rte[3:0]);
    assign inc_routed = (do_pop && self_route) || ((state == RESOLVE) && res_ok);
    assign inc_failed = (state == RESOLVE) && !res_ok && (cur.retry >= RMAX);

    assign rt_req  = (state == ISSUE);
    assign rt_edge = cur.rte;
    assign busy    = (state != IDLE) && (state != FINISH);
    assign done    = (state == FINISH);

    // Tail write data: a re-queued edge wins over the input port.
    always_comb begin
        wr_data.retry = '0;
        wr_data.rte   = in_edge;
        if (requeue) begin
            wr_data.retry = cur.retry + 1'b1;
            wr_data.rte   = cur.rte;
        end
    end

    // FIFO storage, no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    // FIFO pointers, occupancy and end-of-batch flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            last_seen <= 1'b0;
        end else begin
            if (do_wr)  wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_in && in_last) last_seen <= 1'b1;
        end
    end

    // Issue FSM: pop, hand to engine, wait for result, resolve.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cur    <= '0;
            res_ok <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0)   state <= POP;
                    else if (last_seen) state <= FINISH;
                end
                POP: begin
                    cur   <= head;
                    state <= self_route ? IDLE : ISSUE;
                end
                ISSUE: begin
                    if (rt_ack) begin
                        if (rt_done) begin
                            res_ok <= rt_ok;
                            state  <= RESOLVE;
                        end else begin
                            state  <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (rt_done) begin
                        res_ok <= rt_ok;
                        state  <= RESOLVE;
                    end
                end
                RESOLVE: state <= IDLE;
                FINISH:  state <= FINISH;
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating result counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            routed_cnt <= '0;
            failed_cnt <= '0;
        end else begin
            if (inc_routed && (routed_cnt != '1)) routed_cnt <= routed_cnt + 1'b1;
            if (inc_failed && (failed_cnt != '1)) failed_cnt <= failed_cnt + 1'b1;
        end
    end
endmodule

// File: doc/route_edge_scheduler.md
Name: route_edge_scheduler

Overview:
- Sequences edge-routing requests into the CGRA routing engine on the 4x4 grid (16 PEs, 4-bit PE index).
- Buffers incoming edges {src[7:4], dst[3:0]} in a FIFO and issues one edge at a time over a req/ack handshake.
- Collects each routing result and re-queues failed edges at the FIFO tail until MAX_RETRY is exhausted.
- Reports routed/failed counts and done, so the top level knows when the configuration is final.

Parameters:
DEPTH, 16, edge FIFO entries (power of two, >=4)
MAX_RETRY, 2, re-issues allowed per edge after its first failure
CNT_W, 5, width of routed/failed counters

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous active-low reset
in_valid  in  1  edge offered
in_ready  out  1  FIFO accepts edge this cycle
in_edge  in  8  [7:4] source PE, [3:0] destination PE
in_last  in  1  qualifies final edge of batch (sampled with in_valid&&in_ready)
rt_req  out  1  request to routing engine
rt_edge  out  8  edge presented to engine, stable while rt_req=1
rt_ack  in  1  engine accepted edge
rt_done  in  1  one-cycle pulse, result valid
rt_ok  in  1  1 = routed, 0 = failed/blacklisted (valid with rt_done)
routed_cnt  out  CNT_W  edges routed successfully (saturating)
failed_cnt  out  CNT_W  edges dropped after retries (saturating)
busy  out  1  FSM not in IDLE/FINISH
done  out  1  batch complete, held until reset

Behaviour:
- Reset (reset=0, async): FSM=IDLE, FIFO empty (rd/wr ptr=0, count=0), last_seen=0, all outputs 0 except in_ready=1.
- FIFO entry = {retry[ceil(log2(MAX_RETRY+1))-1:0], edge[7:0]}; new input edges enter with retry=0. Pointers wrap modulo DEPTH.
- in_ready = !last_seen && (count < DEPTH-1 while an edge is in flight (POP..RESOLVE), else count < DEPTH). The reserved slot guarantees a re-queue never overflows.
- Edges accepted after in_last are impossible (in_ready=0); last_seen clears only on reset.
- FSM states:
  - IDLE: if count>0 -> POP; else if last_seen -> FINISH.
  - POP: read head into cur, rd_ptr++. If cur.src==cur.dst, routed_cnt++ and -> IDLE without issuing; else -> ISSUE.
  - ISSUE: rt_req=1, rt_edge=cur.edge. Hold until rt_ack=1 -> WAIT (rt_req drops the cycle after ack).
  - WAIT: wait for rt_done. rt_done in the same cycle as rt_ack is legal; latch it and go directly to RESOLVE.
  - RESOLVE, on rt_ok=1: routed_cnt++.
  - RESOLVE, on rt_ok=0 with retry<MAX_RETRY: write {retry+1, edge} at the tail. This write takes priority over the input push, so in_ready=0 in this cycle.
  - RESOLVE, on rt_ok=0 with retry==MAX_RETRY: failed_cnt++.
  - RESOLVE exits -> IDLE in all three cases.
  - FINISH: done=1, busy=0, terminal.
- Counters saturate at 2^CNT_W-1.
- Latency: input accept to rt_req = 2 cycles when FIFO empty and IDLE (write, IDLE->POP->ISSUE).
- Simultaneous push and pop: allowed, count unchanged.
- rt_done/rt_ack outside ISSUE/WAIT are ignored.
- Reset asserted mid-transaction: everything clears immediately, rt_req drops asynchronously, and the in-flight edge is lost.
- Empty batch: in_last with in_valid on the first edge still counts that edge. There is no zero-edge batch.

Test Plan:
- Single edge 0x05, in_last=1; engine acks after 1 cycle and returns rt_ok=1 -> rt_req rises 2 cycles after accept, routed_cnt=1, failed_cnt=0, done=1.
- Edge 0x33 (src==dst) with in_last -> no rt_req ever, routed_cnt=1, done=1.
- Edge 0x0F; engine always returns rt_ok=0, MAX_RETRY=2 -> exactly 3 rt_req transactions with rt_edge=0x0F, failed_cnt=1, done=1.
- Push 16 edges back-to-back with engine stalled (rt_ack=0) -> in_ready drops after 16 pushes, then reserved-slot rule holds count<=15 while one edge is in flight. Fail that edge -> its re-queue lands at the tail with retry=1 and no entry is lost (FIFO order check).
- rt_ack and rt_done pulsed in the same cycle with rt_ok=1 -> counted once, FSM returns to IDLE the cycle after RESOLVE.
- Assert reset low during WAIT with 3 edges queued -> rt_req=0 and busy=0 asynchronously; counts 0; in_ready=1 after release.
